// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - accelerator instruction, FPU request/response and slot types
package acc_pkg;

  localparam int DEFAULT_MAX_OUTSTANDING = 4;
  localparam int TAG_W = 4;

  typedef logic [31:0]      data_t;
  typedef logic [4:0]       reg_addr_t;
  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    fpnew_pkg::operation_e fpu_operation;
  } acc_operation_t;

  typedef struct packed {
    logic           acc_op;
    acc_operation_t operation;
    logic           op_mod;
    data_t          op0;
    data_t          op1;
    data_t          op2;
    reg_addr_t      rd;
  } acc_instr_t;

  typedef struct packed {
    data_t [2:0]            operands;
    fpnew_pkg::operation_e  op;
    logic                   op_mod;
    fpnew_pkg::roundmode_e  rnd_mode;
    fpnew_pkg::fp_format_e  src_fmt;
    fpnew_pkg::fp_format_e  dst_fmt;
    fpnew_pkg::int_format_e int_fmt;
    logic                   vectorial_op;
    logic                   simd_mask;
    tag_t                   tag;
  } fpu_req_t;

  typedef struct packed {
    data_t              result;
    fpnew_pkg::status_t status;
    tag_t               tag;
  } fpu_resp_t;

  typedef struct packed {
    logic      busy;
    reg_addr_t rd;
  } slot_entry_t;

  // Scalar FP32 issue: formats and SIMD controls are fixed, only operands/op/tag vary.
  function automatic fpu_req_t make_fpu_req(acc_instr_t instr, fpnew_pkg::roundmode_e rnd, tag_t tag);
    fpu_req_t r;
    r              = '0;
    r.operands[0]  = instr.op0;
    r.operands[1]  = instr.op1;
    r.operands[2]  = instr.op2;
    r.op           = instr.operation.fpu_operation;
    r.op_mod       = instr.op_mod;
    r.rnd_mode     = rnd;
    r.src_fmt      = fpnew_pkg::FP32;
    r.dst_fmt      = fpnew_pkg::FP32;
    r.int_fmt      = fpnew_pkg::INT32;
    r.vectorial_op = 1'b0;
    r.simd_mask    = 1'b1;
    r.tag          = tag;
    return r;
  endfunction

endpackage

// File: rtl/fpnew_pkg.sv
// rtl/fpnew_pkg.sv - FPU interface enums and status flags shared with the accelerator
package fpnew_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [1:0] {
    INT8  = 2'd0,
    INT16 = 2'd1,
    INT32 = 2'd2,
    INT64 = 2'd3
  } int_format_e;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIVSQRT, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

endpackage

// File: rtl/acc_tag_table.sv
// rtl/acc_tag_table.sv - in-flight slot table: lowest-free allocate, indexed release, busy count
module acc_tag_table
  import acc_pkg::*;
#(
  parameter int  N     = DEFAULT_MAX_OUTSTANDING,
  localparam int IDX_W = $clog2(N),
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_en,
  input  reg_addr_t        alloc_rd,
  input  logic             release_en,
  input  logic [IDX_W-1:0] release_idx,
  output logic             free_avail,
  output logic [IDX_W-1:0] alloc_idx,
  output logic             release_busy,
  output reg_addr_t        release_rd,
  output logic [CNT_W-1:0] busy_count
);

  slot_entry_t slots [N];

  // Priority search uses only registered state, so a slot released this cycle is not reused until the next.
  always_comb begin
    free_avail = 1'b0;
    alloc_idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!slots[i].busy) begin
        free_avail = 1'b1;
        alloc_idx  = IDX_W'(i);
      end
    end
  end

  assign release_busy = slots[release_idx].busy;
  assign release_rd   = slots[release_idx].rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) slots[i] <= '0;
      busy_count <= '0;
    end else begin
      if (release_en) slots[release_idx].busy <= 1'b0;
      if (alloc_en) begin
        slots[alloc_idx].busy <= 1'b1;
        slots[alloc_idx].rd   <= alloc_rd;
      end
      if (alloc_en && !release_en)      busy_count <= busy_count + CNT_W'(1);
      else if (release_en && !alloc_en) busy_count <= busy_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/acc_fpu_issue.sv
// rtl/acc_fpu_issue.sv - issues accelerator instructions to the FPU and routes tagged results to writeback
module acc_fpu_issue
  import acc_pkg::*;
#(
  parameter int                    MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter fpnew_pkg::roundmode_e RND_MODE        = fpnew_pkg::RNE,
  localparam int IDX_W = $clog2(MAX_OUTSTANDING),
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  acc_instr_t         instr_i,
  input  logic               instr_valid_i,
  output logic               instr_ready_o,
  output fpu_req_t           fpu_req_o,
  output logic               fpu_req_valid_o,
  input  logic               fpu_req_ready_i,
  input  fpu_resp_t          fpu_resp_i,
  input  logic               fpu_resp_valid_i,
  output logic               fpu_resp_ready_o,
  output reg_addr_t          wb_rd_o,
  output data_t              wb_data_o,
  output fpnew_pkg::status_t wb_status_o,
  output logic               wb_valid_o,
  input  logic               wb_ready_i,
  output logic [CNT_W-1:0]   outstanding_o,
  output logic               err_o
);

  logic             free_avail;
  logic [IDX_W-1:0] alloc_idx;
  logic             slot_busy;
  reg_addr_t        slot_rd;
  logic             instr_fire;
  logic             alloc_en;
  logic             resp_fire;
  logic             tag_in_range;
  logic             resp_ok;

  // acc_op instructions are always consumable; FPU ones need a slot and room in the request register.
  assign instr_ready_o    = instr_i.acc_op | (free_avail & (~fpu_req_valid_o | fpu_req_ready_i));
  assign instr_fire       = instr_valid_i & instr_ready_o;
  assign alloc_en         = instr_fire & ~instr_i.acc_op;

  assign fpu_resp_ready_o = ~wb_valid_o | wb_ready_i;
  assign resp_fire        = fpu_resp_valid_i & fpu_resp_ready_o;
  assign tag_in_range     = int'(fpu_resp_i.tag) < MAX_OUTSTANDING;
  assign resp_ok          = resp_fire & tag_in_range & slot_busy;

  acc_tag_table #(
    .N (MAX_OUTSTANDING)
  ) u_tag_table (
    .clk          (clk_i),
    .rst          (rst_i),
    .alloc_en     (alloc_en),
    .alloc_rd     (instr_i.rd),
    .release_en   (resp_ok),
    .release_idx  (fpu_resp_i.tag[IDX_W-1:0]),
    .free_avail   (free_avail),
    .alloc_idx    (alloc_idx),
    .release_busy (slot_busy),
    .release_rd   (slot_rd),
    .busy_count   (outstanding_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fpu_req_o       <= '0;
      fpu_req_valid_o <= 1'b0;
      wb_rd_o         <= '0;
      wb_data_o       <= '0;
      wb_status_o     <= '0;
      wb_valid_o      <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      if (alloc_en) begin
        fpu_req_o       <= make_fpu_req(instr_i, RND_MODE, tag_t'(alloc_idx));
        fpu_req_valid_o <= 1'b1;
      end else if (fpu_req_ready_i) begin
        fpu_req_valid_o <= 1'b0;
      end

      if (resp_ok) begin
        wb_rd_o     <= slot_rd;
        wb_data_o   <= fpu_resp_i.result;
        wb_status_o <= fpu_resp_i.status;
        wb_valid_o  <= 1'b1;
      end else if (wb_ready_i) begin
        wb_valid_o <= 1'b0;
      end

      err_o <= (instr_fire & instr_i.acc_op) | (resp_fire & ~resp_ok);
    end
  end

endmodule

// File: tb/tb_acc_fpu_issue.sv
// tb/tb_acc_fpu_issue.sv - directed and randomized checks of acc_fpu_issue against a transaction model
module tb_acc_fpu_issue;
  import acc_pkg::*;

  localparam int N = DEFAULT_MAX_OUTSTANDING;

  typedef struct packed {
    reg_addr_t          rd;
    data_t              data;
    fpnew_pkg::status_t st;
  } wb_t;

  logic               clk = 1'b0;
  logic               rst_i;
  acc_instr_t         instr_i;
  logic               instr_valid_i;
  logic               instr_ready_o;
  fpu_req_t           fpu_req_o;
  logic               fpu_req_valid_o;
  logic               fpu_req_ready_i;
  fpu_resp_t          fpu_resp_i;
  logic               fpu_resp_valid_i;
  logic               fpu_resp_ready_o;
  reg_addr_t          wb_rd_o;
  data_t              wb_data_o;
  fpnew_pkg::status_t wb_status_o;
  logic               wb_valid_o;
  logic               wb_ready_i;
  logic [2:0]         outstanding_o;
  logic               err_o;

  int checks = 0;
  int errors = 0;

  bit        m_busy [N];
  reg_addr_t m_rd   [N];
  fpu_req_t  exp_req[$];
  wb_t       exp_wb [$];
  bit        exp_err;
  bit        instr_fired;
  bit        resp_fired;

  acc_fpu_issue dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .instr_i          (instr_i),
    .instr_valid_i    (instr_valid_i),
    .instr_ready_o    (instr_ready_o),
    .fpu_req_o        (fpu_req_o),
    .fpu_req_valid_o  (fpu_req_valid_o),
    .fpu_req_ready_i  (fpu_req_ready_i),
    .fpu_resp_i       (fpu_resp_i),
    .fpu_resp_valid_i (fpu_resp_valid_i),
    .fpu_resp_ready_o (fpu_resp_ready_o),
    .wb_rd_o          (wb_rd_o),
    .wb_data_o        (wb_data_o),
    .wb_status_o      (wb_status_o),
    .wb_valid_o       (wb_valid_o),
    .wb_ready_i       (wb_ready_i),
    .outstanding_o    (outstanding_o),
    .err_o            (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int busy_cnt();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic fpu_req_t expect_req(acc_instr_t x, int slot);
    fpu_req_t r;
    r              = '0;
    r.operands[0]  = x.op0;
    r.operands[1]  = x.op1;
    r.operands[2]  = x.op2;
    r.op           = x.operation.fpu_operation;
    r.op_mod       = x.op_mod;
    r.rnd_mode     = fpnew_pkg::RNE;
    r.src_fmt      = fpnew_pkg::FP32;
    r.dst_fmt      = fpnew_pkg::FP32;
    r.int_fmt      = fpnew_pkg::INT32;
    r.vectorial_op = 1'b0;
    r.simd_mask    = 1'b1;
    r.tag          = tag_t'(slot);
    return r;
  endfunction

  function automatic acc_instr_t mk_instr(bit acc, fpnew_pkg::operation_e op, data_t a, data_t b, reg_addr_t rd);
    acc_instr_t x;
    x = '0;
    x.acc_op = acc;
    x.operation.fpu_operation = op;
    x.op0 = a;
    x.op1 = b;
    x.rd  = rd;
    return x;
  endfunction

  function automatic acc_instr_t rand_instr();
    acc_instr_t x;
    x.acc_op                  = ($urandom_range(0, 9) == 0);
    x.operation.fpu_operation = fpnew_pkg::operation_e'($urandom_range(0, 14));
    x.op_mod                  = 1'($urandom);
    x.op0                     = $urandom;
    x.op1                     = $urandom;
    x.op2                     = $urandom;
    x.rd                      = 5'($urandom);
    return x;
  endfunction

  // One clock cycle: check outputs against the model, apply this cycle's transfers, advance.
  task automatic step();
    bit e_iready, e_rready, resp_ok_m;
    int lf;
    #1;
    lf       = lowest_free();
    e_iready = instr_i.acc_op || (lf >= 0 && (exp_req.size() == 0 || fpu_req_ready_i));
    e_rready = (exp_wb.size() == 0) || wb_ready_i;
    chk("instr_ready", instr_ready_o, e_iready);
    chk("resp_ready", fpu_resp_ready_o, e_rready);
    chk("req_valid", fpu_req_valid_o, exp_req.size() != 0);
    chk("wb_valid", wb_valid_o, exp_wb.size() != 0);
    chk("err", err_o, exp_err);
    chk("outstanding", outstanding_o, busy_cnt());
    if (exp_req.size() != 0) begin
      chk("req_payload", fpu_req_o, exp_req[0]);
      if (fpu_req_ready_i) void'(exp_req.pop_front());
    end
    if (exp_wb.size() != 0) begin
      chk("wb_payload", {wb_rd_o, wb_data_o, wb_status_o}, exp_wb[0]);
      if (wb_ready_i) void'(exp_wb.pop_front());
    end
    exp_err     = 1'b0;
    resp_fired  = fpu_resp_valid_i && e_rready;
    resp_ok_m   = 1'b0;
    if (resp_fired && int'(fpu_resp_i.tag) < N) resp_ok_m = m_busy[fpu_resp_i.tag];
    instr_fired = instr_valid_i && e_iready;
    if (instr_fired) begin
      if (instr_i.acc_op) exp_err = 1'b1;
      else begin
        m_busy[lf] = 1'b1;
        m_rd[lf]   = instr_i.rd;
        exp_req.push_back(expect_req(instr_i, lf));
      end
    end
    if (resp_fired) begin
      if (resp_ok_m) begin
        exp_wb.push_back({m_rd[fpu_resp_i.tag], fpu_resp_i.result, fpu_resp_i.status});
        m_busy[fpu_resp_i.tag] = 1'b0;
      end else exp_err = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i            = 1'b1;
    instr_valid_i    = 1'b0;
    fpu_resp_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
    exp_req.delete();
    exp_wb.delete();
    exp_err = 1'b0;
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_req_valid", fpu_req_valid_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_req_payload", fpu_req_o, 0);
    chk("rst_wb_payload", {wb_rd_o, wb_data_o, wb_status_o}, 0);
  endtask

  task automatic send_instr(input acc_instr_t x);
    instr_i       = x;
    instr_valid_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (instr_fired) break;
    end
    chk("instr_timeout", instr_fired, 1);
    instr_valid_i = 1'b0;
  endtask

  task automatic send_resp(input tag_t t, input data_t d, input fpnew_pkg::status_t s);
    fpu_resp_i.tag    = t;
    fpu_resp_i.result = d;
    fpu_resp_i.status = s;
    fpu_resp_valid_i  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (resp_fired) break;
    end
    chk("resp_timeout", resp_fired, 1);
    fpu_resp_valid_i = 1'b0;
  endtask

  initial begin
    int  busy_list[$];
    wb_t held;

    instr_i          = '0;
    instr_valid_i    = 1'b0;
    fpu_req_ready_i  = 1'b1;
    fpu_resp_i       = '0;
    fpu_resp_valid_i = 1'b0;
    wb_ready_i       = 1'b1;
    rst_i            = 1'b1;
    @(posedge clk);
    do_reset();

    // Single ADD round trip
    send_instr(mk_instr(0, fpnew_pkg::ADD, 32'h3F80_0000, 32'h4000_0000, 5'd5));
    chk("single_req_tag", fpu_req_o.tag, 0);
    chk("single_req_op0", fpu_req_o.operands[0], 32'h3F80_0000);
    step();
    send_resp(4'd0, 32'h4040_0000, '0);
    chk("single_wb_rd", wb_rd_o, 5);
    chk("single_wb_data", wb_data_o, 32'h4040_0000);
    step();
    chk("single_outstanding", outstanding_o, 0);

    // Fill all slots, fifth stalls until tag 2 is released
    for (int i = 0; i < 4; i++) send_instr(mk_instr(0, fpnew_pkg::MUL, $urandom, $urandom, reg_addr_t'(10 + i)));
    instr_i       = mk_instr(0, fpnew_pkg::ADD, 32'h1, 32'h2, 5'd20);
    instr_valid_i = 1'b1;
    step();
    step();
    chk("fill_stall_ready", instr_ready_o, 0);
    chk("fill_outstanding", outstanding_o, 4);
    fpu_resp_i       = '{result: 32'hAAAA_0000, status: '0, tag: 4'd2};
    fpu_resp_valid_i = 1'b1;
    step();
    chk("fill_same_cycle_no_alloc", instr_fired, 0);
    fpu_resp_valid_i = 1'b0;
    step();
    chk("fill_fifth_fired", instr_fired, 1);
    instr_valid_i = 1'b0;
    chk("fill_fifth_tag", fpu_req_o.tag, 2);
    step();
    foreach (m_busy[i]) if (m_busy[i]) send_resp(tag_t'(i), $urandom, '0);
    step();

    // Out-of-order responses
    do_reset();
    for (int i = 1; i <= 3; i++) send_instr(mk_instr(0, fpnew_pkg::ADD, $urandom, $urandom, reg_addr_t'(i)));
    step();
    send_resp(4'd2, 32'h0000_0003, '0);
    chk("ooo_wb0", wb_rd_o, 3);
    send_resp(4'd0, 32'h0000_0001, '0);
    chk("ooo_wb1", wb_rd_o, 1);
    send_resp(4'd1, 32'h0000_0002, 5'b00001);
    chk("ooo_wb2", wb_rd_o, 2);
    step();

    // Backpressure on writeback and request sides
    wb_ready_i = 1'b0;
    send_instr(mk_instr(0, fpnew_pkg::SQRT, 32'h4080_0000, 32'h0, 5'd7));
    send_resp(4'd0, 32'h4000_0000, 5'b10000);
    chk("bp_resp_ready", fpu_resp_ready_o, 0);
    held = {wb_rd_o, wb_data_o, wb_status_o};
    step();
    step();
    chk("bp_wb_stable", {wb_rd_o, wb_data_o, wb_status_o}, held);
    fpu_req_ready_i = 1'b0;
    send_instr(mk_instr(0, fpnew_pkg::ADD, 32'h5, 32'h6, 5'd8));
    instr_i       = mk_instr(0, fpnew_pkg::MUL, 32'h7, 32'h8, 5'd9);
    instr_valid_i = 1'b1;
    step();
    chk("bp_instr_ready", instr_ready_o, 0);
    step();
    fpu_req_ready_i = 1'b1;
    wb_ready_i      = 1'b1;
    for (int k = 0; k < 10 && !instr_fired; k++) step();
    instr_valid_i = 1'b0;
    step();
    foreach (m_busy[i]) if (m_busy[i]) send_resp(tag_t'(i), $urandom, '0);
    step();

    // Error paths
    send_instr(mk_instr(1, fpnew_pkg::ADD, 32'h0, 32'h0, 5'd1));
    chk("err_acc_op", err_o, 1);
    chk("err_acc_no_req", fpu_req_valid_o, 0);
    send_resp(4'd7, 32'hDEAD_BEEF, '0);
    chk("err_tag7", err_o, 1);
    chk("err_tag7_no_wb", wb_valid_o, 0);
    send_resp(4'd1, 32'hDEAD_BEEF, '0);
    chk("err_free_slot", err_o, 1);
    step();

    // Reset with work in flight, then a stale response
    wb_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send_instr(mk_instr(0, fpnew_pkg::ADD, $urandom, $urandom, reg_addr_t'(i)));
    send_resp(4'd3, 32'h1234_5678, '0);
    chk("pre_rst_outstanding", outstanding_o, 3);
    wb_ready_i = 1'b1;
    do_reset();
    send_resp(4'd1, 32'h1111_1111, '0);
    chk("late_resp_err", err_o, 1);
    chk("late_resp_no_wb", wb_valid_o, 0);
    step();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      fpu_req_ready_i = ($urandom_range(0, 3) != 0);
      wb_ready_i      = ($urandom_range(0, 3) != 0);
      if (!instr_valid_i && $urandom_range(0, 1) == 1) begin
        instr_i       = rand_instr();
        instr_valid_i = 1'b1;
      end
      if (!fpu_resp_valid_i && $urandom_range(0, 1) == 1) begin
        busy_list.delete();
        foreach (m_busy[i]) if (m_busy[i]) busy_list.push_back(i);
        if ($urandom_range(0, 9) == 0) begin
          fpu_resp_i.tag   = tag_t'($urandom_range(0, 15));
          fpu_resp_valid_i = 1'b1;
        end else if (busy_list.size() != 0) begin
          fpu_resp_i.tag   = tag_t'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
          fpu_resp_valid_i = 1'b1;
        end
        fpu_resp_i.result = $urandom;
        fpu_resp_i.status = fpnew_pkg::status_t'(5'($urandom));
      end
      step();
      if (instr_fired) instr_valid_i = 1'b0;
      if (resp_fired) fpu_resp_valid_i = 1'b0;
    end
    instr_valid_i    = 1'b0;
    fpu_resp_valid_i = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
